mem_wb_stage: RTL
=================

// Module: mem_wb_stage
// PURPOSE
//  Memory stage plus MEM/WB pipeline register. Sits directly upstream of the writeback stage.
//  Takes EX/MEM results and performs the load or store on a data-memory request/ack interface.
//  Waits for the access with a small FSM, stalling the front of the pipe while it waits.
//  Aligns and sign/zero-extends load data, then registers everything the writeback stage consumes.
// PARAMETERS
//  TIMEOUT  16  max cycles in WAIT before a bus error is declared; 0 = wait forever
// PORTS
//  clk          in   1   clock; all state updates on rising edge
//  rst          in   1   asynchronous, active-high reset
//  ValidM       in   1   EX/MEM slot holds a real instruction
//  RegWriteM    in   1   instruction writes rd
//  ResultSrcM   in   2   00 ALU, 01 load data, 10 PC+4 (passed to WB)
//  MemReadM     in   1   load
//  MemWriteM    in   1   store (MemReadM&MemWriteM never both 1)
//  funct3M      in   3   000 B, 001 H, 010 W, 100 BU, 101 HU
//  ALUResultM   in   32  effective address / ALU result
//  WriteDataM   in   32  store data (rs2)
//  RdM          in   5   destination register
//  PCPlus4M     in   32  PC+4
//  dmem_req     out  1   access request, held until dmem_ack
//  dmem_we      out  1   1 = store
//  dmem_addr    out  32  {ALUResultM[31:2],2'b00}
//  dmem_wdata   out  32  lane-replicated store data
//  dmem_be      out  4   byte enables
//  dmem_ack     in   1   access complete this cycle; dmem_rdata valid when !dmem_we
//  dmem_rdata   in   32  read word
//  StallM       out  1   freeze IF/ID/EX/MEM registers this cycle
//  RegWriteW, ResultSrcW[1:0], ALUResultW[31:0], RdataW[31:0], RdW[4:0], PCPlus4W[31:0]  out  registered to writeback
//  MisalignW    out  1   registered: misaligned access was dropped
//  BusErrW      out  1   registered: access timed out
// BEHAVIOUR
//  Reset: FSM=IDLE, timeout counter=0, all registered W outputs 0; dmem_req=0, StallM=0.
//  mem_op = ValidM & (MemReadM|MemWriteM). Misaligned: H/HU with addr[0]=1, W with addr[1:0]!=0.
//  Misaligned mem_op: no request issued; W regs load with RegWriteW=0, MisalignW=1; no stall.
//  FSM IDLE: aligned mem_op -> dmem_req=1 combinationally.
//    ack same cycle -> W regs capture, stay IDLE (zero-wait, StallM=0).
//    no ack -> StallM=1, go WAIT.
//  FSM WAIT: dmem_req=1 and StallM=1; address, data, be held stable (inputs frozen by StallM).
//    ack -> StallM=0, W regs capture, go IDLE.
//    counter reaches TIMEOUT-1 without ack -> drop req next cycle, W regs load RegWriteW=0, BusErrW=1, go IDLE.
//  Counter increments each WAIT cycle and clears on leaving WAIT.
//  While StallM=1 the W regs load a bubble: RegWriteW=0, MisalignW=0, BusErrW=0, other fields don't-care.
//  Non-memory ValidM instr: captured directly (1-cycle latency). ValidM=0: bubble.
//  Store: be = B:4'b0001<<a[1:0], H:4'b0011<<a[1:0], W:4'b1111; wdata = B:{4{d[7:0]}}, H:{2{d[15:0]}}, W:d.
//  Load: lane = rdata>>(8*a[1:0]); B/H sign-extend, BU/HU zero-extend, W pass; result registered into RdataW.
//  Stores never set RegWriteW (forced 0 regardless of RegWriteM).
//  MisalignW/BusErrW are single-cycle pulses (cleared by the next capture or bubble).
//  Async reset mid-WAIT: req deasserts immediately, FSM IDLE; no W update for the aborted access.
// TESTING
//  LW a=0x100, ack same cycle rdata=0xDEADBEEF -> StallM never 1; next cycle RdataW=0xDEADBEEF, RegWriteW=1, RdW echoed.
//  LB a=0x103, rdata=0x80112233, ack after 3 cycles -> StallM=1 for 3 cycles with W bubbles; then RdataW=0xFFFFFF80. LBU same -> 0x00000080.
//  SH a=0x102, d=0x0000ABCD -> dmem_be=4'b1100, dmem_wdata=0xABCDABCD, dmem_we=1; RegWriteW=0.
//  LW a=0x101 -> no dmem_req; next cycle MisalignW=1, RegWriteW=0, StallM=0.
//  TIMEOUT=4, no ack -> req held 4 cycles then dropped; BusErrW=1 for one cycle, RegWriteW=0.
//  Assert rst during WAIT -> dmem_req=0 and StallM=0 asynchronously; all W outputs 0.

Source files
------------

// File: rtl/mem_wb_stage_if.sv
// Data-memory request/ack bus between the memory stage and the data memory.
//   master (memory stage): drives dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be;
//                          receives dmem_ack, dmem_rdata.
//   slave  (data memory) : the mirror image.
// A request is held until the cycle in which dmem_ack is seen; dmem_rdata is
// valid in that cycle when dmem_we is 0.
interface mem_wb_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory stage plus MEM/WB pipeline register.
// Performs the load/store of the instruction in the EX/MEM slot over the dmem bus, stalls the
// front of the pipe while the access is outstanding, aligns and extends load data, and
// registers everything the writeback stage consumes.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   *M_i                        EX/MEM slot contents (valid, control, address, store data, rd, PC+4)
//   dmem                        data-memory request/ack bus (master side)
//   StallM_o                    freeze IF/ID/EX/MEM registers this cycle
//   *W_o                        registered writeback-stage inputs
//   MisalignW_o, BusErrW_o      registered one-cycle flags for a dropped or timed-out access
module mem_wb_stage #(
    parameter int unsigned TIMEOUT = 16  // max request cycles before a bus error; 0 = never
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ValidM_i,
    input  logic                  RegWriteM_i,
    input  logic [1:0]            ResultSrcM_i,
    input  logic                  MemReadM_i,
    input  logic                  MemWriteM_i,
    input  logic [2:0]            funct3M_i,
    input  logic [31:0]           ALUResultM_i,
    input  logic [31:0]           WriteDataM_i,
    input  logic [4:0]            RdM_i,
    input  logic [31:0]           PCPlus4M_i,
    mem_wb_stage_if.master        dmem,
    output logic                  StallM_o,
    output logic                  RegWriteW_o,
    output logic [1:0]            ResultSrcW_o,
    output logic [31:0]           ALUResultW_o,
    output logic [31:0]           RdataW_o,
    output logic [4:0]            RdW_o,
    output logic [31:0]           PCPlus4W_o,
    output logic                  MisalignW_o,
    output logic                  BusErrW_o
);
    localparam int unsigned   CntW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT - 1);
    localparam logic          TimeoutEn = (TIMEOUT != 0);

    typedef enum logic {StIdle, StWait} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic        reg_write_q, reg_write_d;
    logic [1:0]  result_src_q, result_src_d;
    logic [31:0] alu_result_q, alu_result_d;
    logic [31:0] rdata_q, rdata_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic        misalign_q, misalign_d;
    logic        bus_err_q, bus_err_d;

    logic        mem_op, misalign, go;
    logic        req, stall, capture, timeout;
    logic [1:0]  a_lo;
    logic [31:0] lane, load_ext;

    assign a_lo     = ALUResultM_i[1:0];
    assign mem_op   = ValidM_i & (MemReadM_i | MemWriteM_i);
    // funct3[1:0] is 01 for H/HU and 10 for W.
    assign misalign = mem_op & (((funct3M_i[1:0] == 2'b01) & a_lo[0]) |
                                ((funct3M_i[1:0] == 2'b10) & (a_lo != 2'b00)));
    assign go       = mem_op & ~misalign;
    // cnt_q already counts the IDLE request cycle, so the request lasts TIMEOUT cycles in total.
    assign timeout  = TimeoutEn & (state_q == StWait) & ~dmem.dmem_ack & (cnt_q >= LastCnt);

    // Request side of the bus; inputs are frozen by StallM while waiting.
    always_comb begin
        dmem.dmem_addr  = {ALUResultM_i[31:2], 2'b00};
        dmem.dmem_we    = MemWriteM_i;
        dmem.dmem_be    = 4'b1111;
        dmem.dmem_wdata = WriteDataM_i;
        unique case (funct3M_i[1:0])
            2'b00: begin
                dmem.dmem_be    = 4'b0001 << a_lo;
                dmem.dmem_wdata = {4{WriteDataM_i[7:0]}};
            end
            2'b01: begin
                dmem.dmem_be    = 4'b0011 << a_lo;
                dmem.dmem_wdata = {2{WriteDataM_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Load alignment and extension.
    always_comb begin
        lane = dmem.dmem_rdata >> {a_lo, 3'b000};
        unique case (funct3M_i)
            3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_ext = {24'h0, lane[7:0]};
            3'b101:  load_ext = {16'h0, lane[15:0]};
            default: load_ext = lane;
        endcase
    end

    // Access FSM: next state, request, stall and capture decisions.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req     = 1'b0;
        stall   = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (go) begin
                    req = 1'b1;
                    if (dmem.dmem_ack) begin
                        capture = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        state_d = StWait;
                        cnt_d   = CntW'(1);
                    end
                end else begin
                    capture = 1'b1;
                end
            end
            StWait: begin
                req = 1'b1;
                if (dmem.dmem_ack) begin
                    capture = 1'b1;
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (timeout) begin
                    // Release the pipe so the failed instruction retires as a bus error.
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Reset must drop the request and stall at once, even though the slot still holds a mem op.
    assign dmem.dmem_req = req & ~rst;
    assign StallM_o      = stall & ~rst;

    // MEM/WB register next state; anything not captured is a bubble.
    always_comb begin
        reg_write_d  = 1'b0;
        result_src_d = '0;
        alu_result_d = '0;
        rdata_d      = '0;
        rd_d         = '0;
        pc_plus4_d   = '0;
        misalign_d   = 1'b0;
        bus_err_d    = timeout;
        if (capture && ValidM_i) begin
            reg_write_d  = RegWriteM_i & ~MemWriteM_i & ~misalign;
            result_src_d = ResultSrcM_i;
            alu_result_d = ALUResultM_i;
            rdata_d      = MemReadM_i ? load_ext : 32'h0;
            rd_d         = RdM_i;
            pc_plus4_d   = PCPlus4M_i;
            misalign_d   = misalign;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            reg_write_q  <= 1'b0;
            result_src_q <= '0;
            alu_result_q <= '0;
            rdata_q      <= '0;
            rd_q         <= '0;
            pc_plus4_q   <= '0;
            misalign_q   <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            reg_write_q  <= reg_write_d;
            result_src_q <= result_src_d;
            alu_result_q <= alu_result_d;
            rdata_q      <= rdata_d;
            rd_q         <= rd_d;
            pc_plus4_q   <= pc_plus4_d;
            misalign_q   <= misalign_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign RegWriteW_o  = reg_write_q;
    assign ResultSrcW_o = result_src_q;
    assign ALUResultW_o = alu_result_q;
    assign RdataW_o     = rdata_q;
    assign RdW_o        = rd_q;
    assign PCPlus4W_o   = pc_plus4_q;
    assign MisalignW_o  = misalign_q;
    assign BusErrW_o    = bus_err_q;
endmodule
